inst_sequencer: RTL

Parametrised multi-cycle instruction sequencer for the NLP-16AF core family. It is the successor to the fixed 16-bit decoder FSM and has four additions over it:
- generic word width
- memory ready handshake with wait states and timeout
- RET instruction
- interrupt entry sequence

It sits between the IR registers and the register file / ALU / memory bus, and drives per-cycle control IDs from common_pkg.

---
 rtl/inst_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer: walks fetch/decode/execute states and emits
// per-cycle ALU, register and memory-bus control IDs, with wait states and IRQ entry.
package common_pkg;
  typedef enum logic [5:0] {
    ALU_ADD = 6'h00, ALU_SUB = 6'h01, ALU_AND = 6'h02, ALU_OR  = 6'h03,
    ALU_XOR = 6'h04, ALU_SHL = 6'h05, ALU_SHR = 6'h06, ALU_MOV = 6'h08,
    ALU_INC = 6'h09, ALU_DEC = 6'h0A
  } alu_op_e;

  // Codes 0..15 are the architectural registers addressed by the 4-bit ra fields.
  typedef enum logic [4:0] {
    R_R0, R_R1, R_R2, R_R3, R_R4, R_R5, R_R6, R_R7,
    R_R8, R_R9, R_R10, R_R11, R_R12, R_R13, R_R14, R_R15,
    R_ZR, R_IP, R_SP, R_MEM, R_IR1, R_IR2, R_IR3, R_ADDR
  } reg_id_e;
endpackage

module inst_sequencer
  import common_pkg::*;
#(
  parameter int DW       = 16,
  parameter int IRQ_EN   = 1,
  parameter int WAIT_MAX = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_ir1,
  input  logic [DW-1:0] i_ir2,
  input  logic          i_mem_ready,
  input  logic          i_irq,
  output logic [4:0]    o_state,
  output logic          o_err,
  output logic          o_irq_ack,
  output alu_op_e       o_alu_op,
  output reg_id_e       o_s1,
  output reg_id_e       o_s2,
  output reg_id_e       o_dest,
  output logic          o_mem_wr,
  output logic          o_mem_rd,
  output reg_id_e       o_addr_reg
);

  localparam int   WCW    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic IRQ_ON = (IRQ_EN != 0);

  typedef enum logic [4:0] {
    S_IF1 = 5'd0, S_D1 = 5'd1, S_IF2 = 5'd2, S_D2 = 5'd3, S_IF3 = 5'd4, S_D3 = 5'd5,
    S_PUSH1 = 5'd6, S_PUSH2 = 5'd7, S_POP1 = 5'd8, S_POP2 = 5'd9, S_EXE = 5'd10,
    S_EXEA = 5'd11, S_RD = 5'd12, S_WR = 5'd13, S_INT1 = 5'd14, S_INT2 = 5'd15,
    S_INT3 = 5'd16, S_HALT = 5'd17
  } st_e;

  typedef struct packed {
    alu_op_e op;
    reg_id_e dest;
    reg_id_e s1;
    reg_id_e s2;
    reg_id_e addr;
  } ctl_t;

  st_e            state_q, nxt, adv, end_st;
  logic [WCW-1:0] wcnt_q;
  logic           err_q, timeout, bad;
  ctl_t           raw;
  logic           mem_wr, mem_rd, mem_acc;

  // Field decode
  logic [3:0] opc, ra1, ra2, ra3;
  alu_op_e    alu_dec;
  reg_id_e    r1, r2, r3;
  logic       is_push, is_pop, is_call, is_ret, is_load, is_store, is_mem, im16;
  logic       unused_ir;

  assign opc      = i_ir1[DW-1 -: 4];
  assign ra1      = i_ir1[3:0];
  assign ra2      = i_ir2[DW-1 -: 4];
  assign ra3      = i_ir2[DW-5 -: 4];
  assign alu_dec  = (opc[3:2] == 2'b00) ? alu_op_e'(i_ir1[DW-3 -: 6])
                                        : alu_op_e'({2'b00, i_ir1[DW-5 -: 4]});
  assign r1       = reg_id_e'({1'b0, ra1});
  assign r2       = reg_id_e'({1'b0, ra2});
  assign r3       = reg_id_e'({1'b0, ra3});
  assign is_push  = (opc == 4'b1101);
  assign is_pop   = (opc == 4'b1100);
  assign is_call  = (opc == 4'b1011);
  assign is_ret   = (opc == 4'b1010);
  assign is_load  = (opc == 4'b1000);
  assign is_store = (opc == 4'b1001);
  assign is_mem   = is_load | is_store;
  assign im16     = (ra2 == 4'd3) | (ra3 == 4'd3);
  assign unused_ir = ^{i_ir1, i_ir2};

  assign end_st = (IRQ_ON && i_irq) ? S_INT1 : S_IF1;

  // Raw per-state controls before memory-port mapping
  always_comb begin
    raw = '{ALU_MOV, R_ZR, R_ZR, R_ZR, R_ZR};
    case (state_q)
      S_IF1:               raw = '{ALU_MOV, R_IR1, R_MEM, R_ZR, R_IP};
      S_IF2:               raw = '{ALU_MOV, R_IR2, R_MEM, R_ZR, R_IP};
      S_IF3:               raw = '{ALU_MOV, R_IR3, R_MEM, R_ZR, R_IP};
      S_D1, S_D2, S_D3:    raw = '{ALU_INC, R_IP, R_IP, R_ZR, R_IP};
      S_PUSH1, S_INT1:     raw = '{ALU_DEC, R_SP, R_SP, R_ZR, R_SP};
      S_PUSH2:             raw = '{ALU_MOV, R_MEM, r1, R_ZR, R_SP};
      S_POP1:              raw = '{ALU_MOV, (is_ret ? R_IP : r1), R_MEM, R_ZR, R_SP};
      S_POP2:              raw = '{ALU_INC, R_SP, R_SP, R_ZR, R_SP};
      S_EXE:               raw = '{alu_dec, r1, r2, r3, R_ZR};
      S_EXEA:              raw = '{alu_dec, R_ADDR, r2, r3, R_ZR};
      S_RD:                raw = '{ALU_MOV, r1, R_MEM, R_ZR, R_ADDR};
      S_WR:                raw = '{ALU_MOV, R_MEM, r1, R_ZR, R_ADDR};
      S_INT2:              raw = '{ALU_MOV, R_MEM, R_IP, R_ZR, R_SP};
      S_INT3:              raw = '{ALU_MOV, R_IP, R_MEM, R_ZR, R_ZR};
      default:             ;
    endcase
  end

  assign mem_wr  = (raw.dest == R_MEM);
  assign mem_rd  = !mem_wr && ((raw.s1 == R_MEM) || (raw.s2 == R_MEM));
  assign mem_acc = mem_wr | mem_rd;

  always_comb begin
    adv = S_IF1;
    bad = 1'b0;
    case (state_q)
      S_IF1:   adv = S_D1;
      S_D1:    adv = is_push ? S_PUSH1 : (is_pop || is_ret) ? S_POP1 : S_IF2;
      S_IF2:   adv = S_D2;
      S_D2:    adv = im16 ? S_IF3 : is_call ? S_PUSH1 : is_mem ? S_EXEA : S_EXE;
      S_IF3:   adv = S_D3;
      S_D3:    adv = is_call ? S_PUSH1 : is_mem ? S_EXEA : S_EXE;
      S_PUSH1: adv = S_PUSH2;
      S_PUSH2: adv = is_call ? S_EXE : end_st;
      S_POP1:  adv = S_POP2;
      S_POP2:  adv = end_st;
      S_EXEA:  adv = is_load ? S_RD : S_WR;
      S_EXE, S_RD, S_WR: adv = end_st;
      S_INT1:  adv = S_INT2;
      S_INT2:  adv = S_INT3;
      S_INT3:  adv = S_IF1;
      S_HALT:  adv = S_HALT;
      default: begin
        adv = S_IF1;
        bad = 1'b1;
      end
    endcase
    timeout = 1'b0;
    nxt     = adv;
    // A ready in the timeout cycle still lets the access complete.
    if (mem_acc && !i_mem_ready) begin
      if (WAIT_MAX != 0 && wcnt_q == WCW'(WAIT_MAX)) begin
        nxt     = S_HALT;
        timeout = 1'b1;
      end else begin
        nxt = state_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IF1;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= nxt;
      err_q   <= err_q | timeout | bad;
      if (nxt != state_q)                wcnt_q <= '0;
      else if (mem_acc && WAIT_MAX != 0) wcnt_q <= wcnt_q + WCW'(1);
    end
  end

  assign o_state    = state_q;
  assign o_err      = err_q;
  assign o_irq_ack  = IRQ_ON && (state_q == S_INT1);
  assign o_alu_op   = raw.op;
  assign o_dest     = mem_wr ? R_ZR : raw.dest;
  assign o_s1       = mem_rd ? R_ZR : raw.s1;
  assign o_s2       = mem_rd ? R_ZR : raw.s2;
  assign o_addr_reg = raw.addr;
  assign o_mem_wr   = mem_wr;
  assign o_mem_rd   = mem_rd;

endmodule
